// File: rtl/booth_pkg.sv
// Shared definitions for the parametrised Booth multiplier: state encodings,
// Booth digit encoding and the radix-2/radix-4 recoding functions.
package booth_pkg;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] EXEC = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   // bit2 = negate, bit1 = select 2M; ZERO is the only all-clear digit
   typedef enum logic [2:0] {
      ZERO = 3'b000,
      POS1 = 3'b001,
      POS2 = 3'b010,
      NEG1 = 3'b101,
      NEG2 = 3'b110
   } booth_digit_t;

   function automatic booth_digit_t booth_digit_r2(input logic [1:0] win);
      case (win)
         2'b01:   return POS1;
         2'b10:   return NEG1;
         default: return ZERO;
      endcase
   endfunction

   function automatic booth_digit_t booth_digit_r4(input logic [2:0] win);
      case (win)
         3'b001, 3'b010: return POS1;
         3'b011:         return POS2;
         3'b100:         return NEG2;
         3'b101, 3'b110: return NEG1;
         default:        return ZERO;
      endcase
   endfunction

endpackage

// File: rtl/booth_recoder.sv
// Combinational Booth recoder: turns the {Q[1],Q[0],Q(-1)} window into a
// signed digit expressed as select-2M / negate / zero controls.
module booth_recoder
   import booth_pkg::*;
(
   input  logic [2:0] win,
   input  logic       radix4,
   output logic       sel_2m,
   output logic       negate,
   output logic       zero
);

   booth_digit_t digit;

   always_comb begin
      digit  = radix4 ? booth_digit_r4(win) : booth_digit_r2(win[1:0]);
      sel_2m = (digit == POS2) || (digit == NEG2);
      negate = (digit == NEG1) || (digit == NEG2);
      zero   = (digit == ZERO);
   end

endmodule

// File: rtl/booth_multiplier_param.sv
// Parametrised signed Booth multiplier (radix-2 or radix-4) with control FSM,
// step counter, shift datapath and registered product output.
module booth_multiplier_param
   import booth_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int RADIX4 = 0,
   localparam int STEPS = (RADIX4 != 0) ? WIDTH / 2 : WIDTH,
   localparam int CNT_W = $clog2(STEPS + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 op_start,
   input  logic                 op_clear,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [1:0]           state,
   output logic [CNT_W-1:0]     cnt,
   output logic                 op_done,
   output logic [2*WIDTH-1:0]   result
);

   localparam int   AW    = WIDTH + 2;
   localparam logic MODE4 = (RADIX4 != 0);

   logic [WIDTH-1:0] m_reg;
   logic [WIDTH-1:0] q_reg;
   logic             q_m1;
   logic [AW-1:0]    a_reg;

   logic             sel_2m, negate, zero;
   logic [AW-1:0]    m_ext, m_term, addend, a_sum, a_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             qm1_nxt;

   booth_recoder u_recoder (
      .win    ({q_reg[1], q_reg[0], q_m1}),
      .radix4 (MODE4),
      .sel_2m (sel_2m),
      .negate (negate),
      .zero   (zero)
   );

   // Two guard bits keep +/-2M and the most-negative operand in range
   always_comb begin
      m_ext  = {{2{m_reg[WIDTH-1]}}, m_reg};
      m_term = sel_2m ? (m_ext << 1) : m_ext;
      if (zero)
         addend = '0;
      else if (negate)
         addend = -m_term;
      else
         addend = m_term;
      a_sum = a_reg + addend;
      if (MODE4) begin
         a_nxt   = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
         q_nxt   = {a_sum[1:0], q_reg[WIDTH-1:2]};
         qm1_nxt = q_reg[1];
      end else begin
         a_nxt   = {a_sum[AW-1], a_sum[AW-1:1]};
         q_nxt   = {a_sum[0], q_reg[WIDTH-1:1]};
         qm1_nxt = q_reg[0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         result <= '0;
         m_reg  <= '0;
         q_reg  <= '0;
         q_m1   <= 1'b0;
         a_reg  <= '0;
      end else if (op_clear) begin
         state  <= IDLE;
         cnt    <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // result is deliberately kept across a restart from DONE
               if (op_start) begin
                  m_reg <= multiplicand;
                  q_reg <= multiplier;
                  q_m1  <= 1'b0;
                  a_reg <= '0;
                  cnt   <= '0;
                  state <= EXEC;
               end
            end
            EXEC: begin
               a_reg <= a_nxt;
               q_reg <= q_nxt;
               q_m1  <= qm1_nxt;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(STEPS - 1)) begin
                  state  <= DONE;
                  result <= {a_nxt[WIDTH-1:0], q_nxt};
               end
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               result <= '0;
            end
         endcase
      end
   end

   assign op_done = (state == DONE);

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Self-checking bench: a 64-bit radix-2 instance and an 8-bit radix-4 instance
// checked against plain signed multiplication, plus clear/restart/reset cases.
module tb_booth_multiplier_param;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic         a_start, a_clear;
   logic [63:0]  a_m, a_q;
   logic [1:0]   a_state;
   logic [6:0]   a_cnt;
   logic         a_done;
   logic [127:0] a_res;

   logic         b_start, b_clear;
   logic [7:0]   b_m, b_q;
   logic [1:0]   b_state;
   logic [2:0]   b_cnt;
   logic         b_done;
   logic [15:0]  b_res;

   booth_multiplier_param #(.WIDTH(64), .RADIX4(0)) dut_a (
      .clk          (clk),
      .reset_n      (reset_n),
      .op_start     (a_start),
      .op_clear     (a_clear),
      .multiplicand (a_m),
      .multiplier   (a_q),
      .state        (a_state),
      .cnt          (a_cnt),
      .op_done      (a_done),
      .result       (a_res)
   );

   booth_multiplier_param #(.WIDTH(8), .RADIX4(1)) dut_b (
      .clk          (clk),
      .reset_n      (reset_n),
      .op_start     (b_start),
      .op_clear     (b_clear),
      .multiplicand (b_m),
      .multiplier   (b_q),
      .state        (b_state),
      .cnt          (b_cnt),
      .op_done      (b_done),
      .result       (b_res)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] prod64(input logic [63:0] m, input logic [63:0] q);
      logic signed [127:0] me, qe;
      me = {{64{m[63]}}, m};
      qe = {{64{q[63]}}, q};
      return me * qe;
   endfunction

   function automatic logic [15:0] prod8(input logic [7:0] m, input logic [7:0] q);
      logic signed [15:0] me, qe;
      me = {{8{m[7]}}, m};
      qe = {{8{q[7]}}, q};
      return me * qe;
   endfunction

   task automatic start_a(input string tag, input logic [63:0] m, input logic [63:0] q);
      a_m = m;
      a_q = q;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk({tag, " accept state"}, 128'(a_state), 128'(2'b01));
   endtask

   task automatic wait_a(input string tag, input int already, input logic [127:0] exp);
      int cyc;
      cyc = already;
      while (a_done !== 1'b1 && cyc < 200) begin
         tick();
         cyc++;
      end
      chk({tag, " latency"}, 128'(cyc), 128'(64));
      chk({tag, " result"}, a_res, exp);
      chk({tag, " cnt"}, 128'(a_cnt), 128'(64));
      chk({tag, " state"}, 128'(a_state), 128'(2'b10));
   endtask

   task automatic run_b(input string tag, input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp);
      int cyc;
      b_m = m;
      b_q = q;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      cyc = 0;
      while (b_done !== 1'b1 && cyc < 50) begin
         tick();
         cyc++;
      end
      chk({tag, " latency"}, 128'(cyc), 128'(4));
      chk({tag, " result"}, 128'(b_res), 128'(exp));
      chk({tag, " cnt"}, 128'(b_cnt), 128'(4));
   endtask

   initial begin
      logic [63:0] rm, rq;
      logic [7:0]  sm, sq;
      logic        seen;

      reset_n = 1'b0;
      a_start = 1'b0; a_clear = 1'b0; a_m = '0; a_q = '0;
      b_start = 1'b0; b_clear = 1'b0; b_m = '0; b_q = '0;
      #7 reset_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle a state", 128'(a_state), 128'(0));
         chk("idle a cnt", 128'(a_cnt), 128'(0));
         chk("idle a done", 128'(a_done), 128'(0));
         chk("idle a result", a_res, 128'(0));
         chk("idle b result", 128'(b_res), 128'(0));
      end

      start_a("r2 3x-5", 64'd3, -64'sd5);
      wait_a("r2 3x-5", 0, {{124{1'b1}}, 4'b0001});
      repeat (5) tick();
      chk("r2 hold result", a_res, {{124{1'b1}}, 4'b0001});
      chk("r2 hold done", 128'(a_done), 128'(1));
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      chk("clear state", 128'(a_state), 128'(0));
      chk("clear result", a_res, 128'(0));

      start_a("r2 minmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      wait_a("r2 minmin", 0, 128'h4000_0000_0000_0000_0000_0000_0000_0000);

      for (int i = 0; i < 4; i++) begin
         rm = {$urandom, $urandom};
         rq = {$urandom, $urandom};
         start_a("r2 rand", rm, rq);
         wait_a("r2 rand", 0, prod64(rm, rq));
      end

      start_a("b2b first", 64'd3, 64'd7);
      wait_a("b2b first", 0, 128'd21);
      a_m = -64'sd2;
      a_q = 64'd6;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk("b2b done fall", 128'(a_done), 128'(0));
      chk("b2b state", 128'(a_state), 128'(2'b01));
      chk("b2b keep result", a_res, 128'd21);
      repeat (10) tick();
      chk("b2b mid result", a_res, 128'd21);
      wait_a("b2b second", 10, prod64(-64'sd2, 64'd6));

      start_a("abort", 64'd7, 64'd9);
      repeat (10) tick();
      chk("abort pre cnt", 128'(a_cnt), 128'(10));
      a_clear = 1'b1;
      a_start = 1'b1;
      tick();
      a_clear = 1'b0;
      a_start = 1'b0;
      chk("abort state", 128'(a_state), 128'(0));
      chk("abort cnt", 128'(a_cnt), 128'(0));
      chk("abort result", a_res, 128'(0));
      chk("abort done", 128'(a_done), 128'(0));
      seen = 1'b0;
      repeat (80) begin
         tick();
         if (a_done === 1'b1) seen = 1'b1;
      end
      chk("abort no done", 128'(seen), 128'(0));

      run_b("r4 minmin", 8'h80, 8'h80, 16'h4000);
      run_b("r4 max x min", 8'h7F, 8'h80, 16'hC080);
      for (int i = 0; i < 20; i++) begin
         sm = 8'($urandom);
         sq = 8'($urandom);
         run_b("r4 rand", sm, sq, prod8(sm, sq));
      end

      start_a("areset", {$urandom, $urandom}, {$urandom, $urandom});
      repeat (30) tick();
      chk("areset pre cnt", 128'(a_cnt), 128'(30));
      #3 reset_n = 1'b0;
      #1;
      chk("areset state", 128'(a_state), 128'(0));
      chk("areset cnt", 128'(a_cnt), 128'(0));
      chk("areset done", 128'(a_done), 128'(0));
      chk("areset result", a_res, 128'(0));
      chk("areset b result", 128'(b_res), 128'(0));
      #2 reset_n = 1'b1;
      repeat (5) tick();
      chk("post reset state", 128'(a_state), 128'(0));
      chk("post reset done", 128'(a_done), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/booth_multiplier_param.md
Name: booth_multiplier_param

Overview:
Parametrised signed Booth multiplier with integrated control FSM, successor to the fixed 64-cycle radix-2 next-state/counter block. It generalises operand width and adds a radix-4 mode, which halves the step count. It adds a registered product output and back-to-back restart from DONE. It sits in the multiplier subsystem and is driven by the op_start/op_clear handshake from the host controller.

Parameters:
WIDTH, 64, operand width in bits; must be >= 4, and even when RADIX4=1.
RADIX4, 0, 0 = radix-2 Booth (1 bit per step), 1 = radix-4 Booth (2 bits per step).
STEPS (localparam), RADIX4 ? WIDTH/2 : WIDTH, Booth steps per operation.
CNT_W (localparam), $clog2(STEPS+1), counter width (7 for WIDTH=64, RADIX4=0).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
op_start  input  1  start request; sampled in IDLE or DONE.
op_clear  input  1  synchronous clear; highest priority.
multiplicand  input  WIDTH  signed operand M; latched on the accepted start.
multiplier  input  WIDTH  signed operand Q; latched on the accepted start.
state  output  2  current state: IDLE=2'b00, EXEC=2'b01, DONE=2'b10.
cnt  output  CNT_W  count of completed Booth steps.
op_done  output  1  result valid; high exactly while state==DONE.
result  output  2*WIDTH  signed product M*Q; valid while op_done=1.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, cnt=0, op_done=0, result=0, internal accumulator and latched operands = 0.
- Priority at each rising edge: op_clear, then start acceptance, then step execution.
- op_clear=1, any state: next state=IDLE, cnt=0, result=0, op_done=0. It aborts an operation in progress. op_start in the same cycle is ignored.
- IDLE: if op_start=1, latch M and Q, clear the accumulator A to 0, set Q(-1)=0, cnt=0, go to EXEC. Otherwise hold.
- EXEC: one Booth step per cycle, cnt+=1. op_start is ignored.
- Radix-2 step: recode {Q[0],Q(-1)}. 01 means A+=M; 10 means A-=M; 00 and 11 mean no change. Then arithmetic-shift {A,Q,Q(-1)} right by 1.
- Radix-4 step: recode {Q[1],Q[0],Q(-1)} into a digit in {-2,-1,0,+1,+2}. Add the digit times M to A, then arithmetic-shift {A,Q,Q(-1)} right by 2.
- Accumulator width is WIDTH+2 (sign-extended) so that +/-2M and the most-negative operands cannot overflow.
- When the step that makes cnt==STEPS completes: go to DONE, op_done=1, result={A,Q} truncated to the low 2*WIDTH bits (sign-correct).
- Latency: op_start is accepted at edge E0. state==EXEC after E0. state==DONE and op_done=1 after edge E0+STEPS. For the defaults that is 64 cycles; with RADIX4=1 it is 32 cycles.
- DONE: result, cnt (=STEPS) and op_done are held. If op_start=1 (and op_clear=0), new operands are latched and the block goes to EXEC. op_done falls at that edge and result is retained until the new completion.
- Unused state encoding 2'b11 goes to IDLE on the next edge with all outputs cleared.
- reset_n asserted mid-operation: immediate return to the reset values above, with no partial result.
- Operands are two's complement. The product of -2^(WIDTH-1) and -2^(WIDTH-1) must give +2^(2*WIDTH-2) exactly.

Decomposition:
- Package booth_pkg: state encoding localparams (IDLE, EXEC, DONE); the Booth digit enum/encoding (ZERO, POS1, POS2, NEG1, NEG2); the function booth_digit_r2 and the function booth_digit_r4.
- Sub-module booth_recoder: combinational. Inputs are the 3-bit window and the RADIX4 mode. Outputs are the digit (sel_2m, negate, zero).
- The FSM, counter and shift datapath stay in booth_multiplier_param.

Test Plan:
- Reset/idle: hold reset_n=0 for 7 ns, then release with op_start=0 -> state=00, cnt=0, op_done=0, result=0 for 20 cycles.
- Basic radix-2 (WIDTH=64): M=3, Q=-5, pulse op_start -> op_done=1 exactly 64 cycles after acceptance, result=-15 (0xFFFF...FFF1), cnt=64, held until op_clear.
- Radix-4 (WIDTH=8, RADIX4=1): M=-128, Q=-128 -> op_done after 4 cycles, result=16'h4000. Repeat with M=127, Q=-128 -> result=16'hC080.
- Abort: start with M=7, Q=9, assert op_clear after 10 EXEC cycles -> next edge state=00, cnt=0, result=0, op_done=0. No op_done pulse follows.
- Back-to-back: in DONE with result=21 (M=3, Q=7), assert op_start with M=-2, Q=6 -> op_done falls, state=01, result stays 21 during EXEC, then result=-12 with op_done=1 after STEPS cycles.
- Async reset mid-EXEC: drop reset_n between edges at cnt=30 -> all outputs go to their reset values immediately, without waiting for a clock edge. After release, the block stays in IDLE until op_start.
